// File: rtl/count_run_ctrl.sv
// count_run_ctrl: run controller feeding the enable input of a 4-bit counter.
// A single start request produces an enable window of exactly run_len cycles.
// In repeat mode, runs of the same length follow each other, separated by a
// fixed idle gap, until stop is asserted or the repeat request is dropped.
// Outputs: busy status, a one-cycle done pulse per completed run, and a
// modulo-16 count of completed runs.
//
// The repeat request port is named repeat_req because repeat is a reserved
// word in SystemVerilog.

module count_run_ctrl #(
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_CYCLES = 4   // enable-low cycles between repeated runs, >= 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 repeat_req,
  input  logic [LEN_WIDTH-1:0] run_len,
  output logic                 enable,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           runs_done
);

  // The gap counter holds GAP_CYCLES down to 1. Its width covers the value
  // GAP_CYCLES itself.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e               state_q,  state_d;
  logic [LEN_WIDTH-1:0] len_q,    len_d;     // run length latched at start
  logic [LEN_WIDTH-1:0] rem_q,    rem_d;     // enable cycles left, current one included
  logic [GAP_W-1:0]     gap_q,    gap_d;     // gap cycles left, current one included
  logic                 enable_q, enable_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [3:0]           runs_q,   runs_d;

  // Next-state and next-output logic. Outputs are computed one cycle early so
  // that they come straight from flops.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d  = state_q;
    len_d    = len_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    runs_d   = runs_q;

    unique case (state_q)
      IDLE: begin
        // stop has priority over start. A zero length is not a valid run.
        if (start && !stop && (run_len != '0)) begin
          state_d  = RUN;
          len_d    = run_len;
          rem_d    = run_len;
          enable_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      RUN: begin
        if (stop) begin
          // An abort on the final cycle also cancels that run's done and count.
          state_d  = IDLE;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (rem_q == LEN_WIDTH'(1)) begin
          // This is the last enable cycle. The run completes on this edge.
          enable_d = 1'b0;
          done_d   = 1'b1;
          runs_d   = runs_q + 4'd1;
          rem_d    = '0;
          if (repeat_req) begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYCLES);
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          rem_d = rem_q - LEN_WIDTH'(1);
        end
      end

      GAP: begin
        if (stop) begin
          state_d  = IDLE;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (gap_q == GAP_W'(1)) begin
          // Each repeated run uses the latched length. Live run_len is ignored.
          state_d  = RUN;
          rem_d    = len_q;
          enable_d = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        // Unreachable encoding. Fall back to a quiet IDLE.
        state_d  = IDLE;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and has highest priority.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order these statements are in.
    if (reset) begin
      // NOTE: all state is small flop storage (no memories), so every register
      // is cleared. A reset mid-run leaves no stale length behind.
      state_q  <= IDLE;
      len_q    <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      runs_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      runs_q   <= runs_d;
    end
  end

  assign enable    = enable_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign runs_done = runs_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// tb_count_run_ctrl: directed bench for count_run_ctrl. It drives inputs after
// each falling edge and samples outputs at the next falling edge. A small
// enable-gated 4-bit counter models the downstream counter.

module tb_count_run_ctrl;

  localparam int LEN_WIDTH  = 8;
  localparam int GAP_CYCLES = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 stop;
  logic                 repeat_req;
  logic [LEN_WIDTH-1:0] run_len;
  logic                 enable;
  logic                 busy;
  logic                 done;
  logic [3:0]           runs_done;

  int checks = 0;
  int errors = 0;

  logic [3:0] cnt;       // downstream counter model
  int         runs_exp;  // expected completed-run count, before wrapping

  count_run_ctrl #(
    .LEN_WIDTH  (LEN_WIDTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .repeat_req (repeat_req),
    .run_len    (run_len),
    .enable     (enable),
    .busy       (busy),
    .done       (done),
    .runs_done  (runs_done)
  );

  always #5 clock = ~clock;

  // Downstream counter. It shares clock and reset with the controller.
  always_ff @(posedge clock) begin
    if (reset) cnt <= '0;
    else if (enable) cnt <= cnt + 4'd1;
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic en, input logic bz,
                            input logic dn, input int rd);
    check({tag, ".enable"},    32'(enable),    32'(en));
    check({tag, ".busy"},      32'(busy),      32'(bz));
    check({tag, ".done"},      32'(done),      32'(dn));
    check({tag, ".runs_done"}, 32'(runs_done), 32'(rd % 16));
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    repeat_req = 1'b0;
    run_len    = '0;
    runs_exp   = 0;

    // Reset for 2 cycles.
    cyc(); cyc();
    expect_out("reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    cyc();
    expect_out("post_reset", 1'b0, 1'b0, 1'b0, 0);

    // Single run of 5. Enable rises one cycle after start.
    start = 1'b1; run_len = 8'd5; repeat_req = 1'b0;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("single.run%0d", i), 1'b1, 1'b1, 1'b0, runs_exp);
      cyc();
    end
    runs_exp++;
    expect_out("single.done", 1'b0, 1'b0, 1'b1, runs_exp);
    check("single.counter", 32'(cnt), 32'd5);
    cyc();
    expect_out("single.after", 1'b0, 1'b0, 1'b0, runs_exp);

    // Repeat mode with length 3. run_len changes to 7 mid-run, which has no
    // effect. repeat is dropped during the third run.
    start = 1'b1; run_len = 8'd3; repeat_req = 1'b1;
    cyc();
    start = 1'b0; run_len = 8'd7;
    for (int r = 0; r < 3; r++) begin
      if (r == 2) repeat_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        expect_out($sformatf("rep.r%0d.en%0d", r, i), 1'b1, 1'b1, 1'b0, runs_exp);
        cyc();
      end
      runs_exp++;
      if (r < 2) begin
        expect_out($sformatf("rep.r%0d.gap0", r), 1'b0, 1'b1, 1'b1, runs_exp);
        cyc();
        for (int g = 1; g < GAP_CYCLES; g++) begin
          expect_out($sformatf("rep.r%0d.gap%0d", r, g), 1'b0, 1'b1, 1'b0, runs_exp);
          cyc();
        end
      end else begin
        expect_out("rep.last_done", 1'b0, 1'b0, 1'b1, runs_exp);
        cyc();
      end
    end
    expect_out("rep.idle", 1'b0, 1'b0, 1'b0, runs_exp);
    check("rep.counter", 32'(cnt), 32'd14);

    // Stop on the 4th enable cycle of a run of 10.
    start = 1'b1; run_len = 8'd10;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("stop.en%0d", i), 1'b1, 1'b1, 1'b0, runs_exp);
      if (i == 3) stop = 1'b1;
      cyc();
    end
    stop = 1'b0;
    expect_out("stop.aborted", 1'b0, 1'b0, 1'b0, runs_exp);
    cyc();
    expect_out("stop.idle", 1'b0, 1'b0, 1'b0, runs_exp);
    check("stop.counter", 32'(cnt), 32'd2);

    // A new run of 2 after the abort.
    start = 1'b1; run_len = 8'd2;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_out($sformatf("len2.en%0d", i), 1'b1, 1'b1, 1'b0, runs_exp);
      cyc();
    end
    runs_exp++;
    expect_out("len2.done", 1'b0, 1'b0, 1'b1, runs_exp);
    cyc();
    check("len2.counter", 32'(cnt), 32'd4);

    // A start with length 0 is ignored.
    start = 1'b1; run_len = 8'd0;
    cyc();
    start = 1'b0;
    expect_out("zero_len", 1'b0, 1'b0, 1'b0, runs_exp);
    cyc();
    expect_out("zero_len.idle", 1'b0, 1'b0, 1'b0, runs_exp);

    // start and stop in the same cycle: stop wins.
    start = 1'b1; stop = 1'b1; run_len = 8'd4;
    cyc();
    start = 1'b0; stop = 1'b0;
    expect_out("start_stop", 1'b0, 1'b0, 1'b0, runs_exp);
    cyc();
    expect_out("start_stop.idle", 1'b0, 1'b0, 1'b0, runs_exp);

    // Maximum length of 255. The enable count is bounded.
    start = 1'b1; run_len = 8'd255;
    cyc();
    start = 1'b0;
    n = 0;
    while (enable === 1'b1 && n < 300) begin
      n++;
      cyc();
    end
    runs_exp++;
    check("len255.cycles", 32'(n), 32'd255);
    expect_out("len255.done", 1'b0, 1'b0, 1'b1, runs_exp);
    check("len255.counter", 32'(cnt), 32'd3);
    cyc();

    // Reset during GAP with runs_done = 2.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    runs_exp = 0;
    expect_out("rst2", 1'b0, 1'b0, 1'b0, runs_exp);
    start = 1'b1; run_len = 8'd2; repeat_req = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();                       // run 1: 2 enable cycles
    expect_out("gaprst.gap_a", 1'b0, 1'b1, 1'b1, 1);
    cyc(); cyc(); cyc(); cyc();         // rest of the gap, then run 2 cycle 1
    expect_out("gaprst.run2", 1'b1, 1'b1, 1'b0, 1);
    cyc();
    cyc();
    expect_out("gaprst.gap_b", 1'b0, 1'b1, 1'b1, 2);
    cyc();
    expect_out("gaprst.gap_b1", 1'b0, 1'b1, 1'b0, 2);
    reset = 1'b1;
    cyc();
    reset = 1'b0; repeat_req = 1'b0;
    expect_out("gaprst.cleared", 1'b0, 1'b0, 1'b0, 0);
    cyc();
    expect_out("gaprst.idle", 1'b0, 1'b0, 1'b0, 0);
    start = 1'b1; run_len = 8'd1;
    cyc();
    start = 1'b0;
    expect_out("gaprst.restart_en", 1'b1, 1'b1, 1'b0, 0);
    cyc();
    expect_out("gaprst.restart_done", 1'b0, 1'b0, 1'b1, 1);
    cyc();

    // Wrap: 17 single runs of length 1 after a fresh reset.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      start = 1'b1; run_len = 8'd1;
      cyc();
      start = 1'b0;
      expect_out($sformatf("wrap%0d.en", k), 1'b1, 1'b1, 1'b0, k);
      cyc();
      expect_out($sformatf("wrap%0d.done", k), 1'b0, 1'b0, 1'b1, k + 1);
      cyc();
    end
    check("wrap.final", 32'(runs_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_run_ctrl.md
Name: count_run_ctrl

Overview:
- Upstream run controller for the 4-bit enable-gated counter. It converts a one-cycle start request into an enable window that lasts exactly run_len clock cycles, so the counter advances a known number of steps.
- Optionally repeats runs, separated by a fixed idle gap, until stopped.
- Reports busy status, a one-cycle done pulse per completed run, and a wrapping count of completed runs.
- enable connects directly to the counter's enable input. The block shares the counter's clock and reset.

Parameters:
- LEN_WIDTH, 8, width of run_len and of the internal remaining-cycles counter.
- GAP_CYCLES, 4, enable-low cycles between consecutive runs in repeat mode. Must be at least 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
- start  in  1  run request, sampled only in IDLE.
- stop  in  1  abort request, sampled in every state.
- repeat  in  1  sampled on the last enable cycle of each run; when 1, start another run after the gap.
- run_len  in  LEN_WIDTH  enable-window length in cycles, latched when start is accepted.
- enable  out  1  counter enable, registered.
- busy  out  1  high in RUN and GAP, registered.
- done  out  1  one-cycle pulse after each completed run, registered.
- runs_done  out  4  number of completed runs, wraps 15 to 0.

Behaviour:
- Reset: synchronous, active-high, highest priority.
  - Next state is IDLE.
  - enable, busy, done, runs_done all 0; the internal length and remaining counters are cleared.
  - Reset during RUN or GAP aborts at once: no done pulse, runs_done cleared.
- States: IDLE, RUN, GAP. All outputs are registered and change only on clock edges.
- IDLE:
  - start=1, stop=0, run_len!=0 at edge k:
    - latch len_q = run_len and load remaining = run_len;
    - after edge k: RUN, enable=1, busy=1. Latency from start to enable is 1 cycle.
  - start with run_len=0: ignored; stay IDLE, no done, no runs_done change.
  - start and stop together: stop wins; stay IDLE.
- RUN:
  - enable is high for exactly len_q consecutive cycles; remaining decrements once per cycle.
  - On the edge that ends the last enable cycle (remaining=1, stop=0):
    - done=1 for one cycle and runs_done increments;
    - repeat=1 on that edge: go to GAP, busy stays 1;
    - repeat=0: go to IDLE, busy=0.
  - run_len and start changes during RUN are ignored; len_q is stable until the next accepted start.
- GAP:
  - enable=0 and busy=1 for exactly GAP_CYCLES cycles. The first GAP cycle coincides with the done pulse.
  - Then return to RUN, reloading remaining from len_q (not the live run_len).
  - repeat is not re-sampled in GAP.
- stop in RUN or GAP: next cycle is IDLE with enable=0, busy=0, no done pulse, runs_done unchanged.
  - stop on the final enable cycle of a run also cancels that run's done pulse and increment.
- runs_done arithmetic: 4-bit modulo-16; 15+1 gives 0.
- done never asserts on consecutive cycles, because GAP_CYCLES is at least 1 and non-repeat returns to IDLE.
- Single run of N cycles: counter sees exactly N enable cycles and advances by N mod 16.

Test Plan:
- Single run: reset 2 cycles; start=1 for 1 cycle, run_len=5, repeat=0 -> enable high exactly 5 cycles starting 1 cycle after start. Then done=1 for 1 cycle with busy=0, runs_done=1. Downstream counter goes 0 to 5.
- Repeat mode: run_len=3, repeat=1, GAP_CYCLES=4 -> enable pattern 3 high / 4 low repeating. done pulses align with the first low cycle of each gap. After 3 runs, runs_done=3.
  - Drop repeat during the third run -> IDLE after that run's done, busy=0.
- Stop mid-run: run_len=10, assert stop on the 4th enable cycle -> enable low the next cycle, busy=0, no done, runs_done unchanged. A new start with run_len=2 gives exactly 2 enable cycles.
- Boundaries:
  - start with run_len=0 -> no state change.
  - start+stop in the same IDLE cycle -> no run.
  - Change run_len to 7 during a repeat run of 3 -> subsequent runs stay at 3 cycles.
  - run_len=255 -> exactly 255 enable cycles.
- Reset mid-operation: reset during GAP with runs_done=2 -> next cycle all outputs 0, runs_done=0, state IDLE. The following start works normally.
- Wrap: 17 single runs of length 1 -> runs_done reads 15 after the 15th run, then 0, then 1.
